decode: RTL and testbench
=========================

# decode

Instruction-decode stage of the ARC MIPS pipeline, directly downstream of `fetch`. Holds the IF/ID pipeline register and the 32×32 general-purpose register file. Detects load-use hazards and back-pressures fetch. Produces register operands, immediate, field decodes and the branch target for the execute stage.

## Interface
Parameters:
- `NOP_INSTR`, default `32'h0000_0000`: instruction word loaded into IF/ID on reset and flush (`sll $0,$0,0`).

Ports:
- `i_clk` in 1: clock. All state updates on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_data_Instr` in 32: instruction word from `fetch`.
- `i_addr_NextPC` in 32: PC+4 from `fetch`.
- `i_con_Stall` in 1: external stall. IF/ID holds.
- `i_con_Flush` in 1: squash. IF/ID is loaded with a bubble.
- `i_con_RegWrite` in 1: write-back enable.
- `i_addr_WriteReg` in 5: write-back register index.
- `i_data_WriteData` in 32: write-back data.
- `i_con_ExMemRead` in 1: the instruction now in ID/EX is a load.
- `i_addr_ExRt` in 5: destination (rt) of that load.
- `o_con_Stall` out 1: load-use stall. Fetch must hold PC.
- `o_con_Valid` out 1: decode outputs carry a real instruction.
- `o_data_Opcode` out 6: instr[31:26].
- `o_data_Funct` out 6: instr[5:0].
- `o_addr_Rs`, `o_addr_Rt`, `o_addr_Rd` out 5 each: instr[25:21], [20:16], [15:11].
- `o_data_ReadData1`, `o_data_ReadData2` out 32 each: register file values at indices rs and rt.
- `o_data_SignImm` out 32: sign-extended instr[15:0].
- `o_addr_NextPC` out 32: PC+4 held in IF/ID.
- `o_addr_BranchTarget` out 32: `NextPC + (SignImm << 2)`, modulo 2^32.

## Operation
- **IF/ID register.** Fields are `instr`, `nextpc` and `valid`. Each edge applies the first matching rule:
  1. `i_con_Flush=1`: instr←`NOP_INSTR`, nextpc←0, valid←0. Flush beats every stall.
  2. `i_con_Stall=1` or `o_con_Stall=1`: hold all fields.
  3. Otherwise: instr←`i_data_Instr`, nextpc←`i_addr_NextPC`, valid←1.
- **Load-use hazard.** `o_con_Stall = i_con_ExMemRead & (i_addr_ExRt != 0) & (i_addr_ExRt == rs | i_addr_ExRt == rt)`.
  - The check is combinational on the held IF/ID instruction.
  - The check is not masked by `valid`, so a false stall on a bubble is permitted.
- **`o_con_Valid`** = `valid & ~o_con_Stall`. The stalled cycle presents a bubble to execute.
- **Register file.**
  - $0 always reads 0 and ignores writes.
  - A write occurs on the edge when `i_con_RegWrite=1` and `i_addr_WriteReg != 0`.
  - Writes are never blocked by stall or flush.
  - Reads are combinational from rs/rt.
- **Decoded fields.** All field, immediate and target outputs are combinational from IF/ID. They are driven even when `o_con_Valid=0`.

## Timing
- **Reset (`i_rst_n=0`, asynchronous).**
  - IF/ID: instr=`NOP_INSTR`, nextpc=0, valid=0.
  - All 32 registers cleared to 0.
  - Resulting outputs: `o_con_Valid=0`, `o_addr_NextPC=0`, `o_addr_BranchTarget=0`, `o_data_ReadData1/2=0`, `o_data_SignImm=0`, all field outputs from `NOP_INSTR` (0 by default).
  - `o_con_Stall` follows its inputs.
- **Reset release.** The first rising edge with `i_rst_n=1` loads the first instruction.
- **Reset mid-stall.** Reset discards held state immediately, without waiting for an edge.
- **Latency.** An instruction presented by fetch at edge N is decoded in the cycle after edge N, i.e. one cycle.
- **Load-use hazard.** Stalls exactly one cycle, because the load advances out of ID/EX.
- **Stall followed by flush.** The flush is taken on that edge.
- **Write-back to a register read in the same cycle.** Without bypass, the old value is read; the new value is visible from the next cycle.

## Configuration
- **`DECODE_REGFILE_BYPASS_EN` defined.**
  - When `i_con_RegWrite=1` and `i_addr_WriteReg != 0` equals rs (or rt), the matching read port returns `i_data_WriteData` in the same cycle. This is write-through.
  - $0 is never bypassed.
- **Undefined.** No bypass. Reads return the stored value only. External forwarding or an extra stall covers the hazard.

## Test plan
- **Reset.** Assert `i_rst_n=0` mid-cycle with valid=1 → `o_con_Valid`, `o_addr_NextPC` and `o_data_ReadData1` drop to 0 before the next edge.
- **Normal decode.** Write r8=`0x1234_5678`. Then present `0x8D09FFFC` (lw $9,-4($8)) with NextPC=`0x0000_0104` → next cycle:
  - `o_addr_Rs=8`, `o_addr_Rt=9`
  - `o_data_ReadData1=0x1234_5678`
  - `o_data_SignImm=0xFFFF_FFFC`
  - `o_addr_BranchTarget=0x0000_00F4`
  - `o_con_Valid=1`
- **Load-use.** IF/ID holds `add $10,$9,$9` with `i_con_ExMemRead=1`, `i_addr_ExRt=9` → `o_con_Stall=1` and `o_con_Valid=0` for one cycle, IF/ID unchanged. With `i_addr_ExRt=0`, there is no stall.
- **Flush beats stall.** Assert `i_con_Flush=1` together with `i_con_Stall=1` → next cycle instr=`NOP_INSTR` and `o_con_Valid=0`.
- **$0 and write/read collision.** Write `0xDEAD_BEEF` to r0 → reads 0. Write `0xCAFE_0001` to r5 while rs=5:
  - Same cycle, with `DECODE_REGFILE_BYPASS_EN`: `0xCAFE_0001`.
  - Same cycle, without the macro: prior value.
  - Next cycle: `0xCAFE_0001` in both builds.
- **Wrap.** NextPC=`0xFFFF_FFFC` with imm=`0x0001` → `o_addr_BranchTarget=0x0000_0000`.

Source files
------------

// File: rtl/decode.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file, load-use stall.
// Optional same-cycle write-through on the read ports when DECODE_REGFILE_BYPASS_EN is defined.
module decode #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_data_Instr,
   input  logic [31:0] i_addr_NextPC,
   input  logic        i_con_Stall,
   input  logic        i_con_Flush,
   input  logic        i_con_RegWrite,
   input  logic [4:0]  i_addr_WriteReg,
   input  logic [31:0] i_data_WriteData,
   input  logic        i_con_ExMemRead,
   input  logic [4:0]  i_addr_ExRt,
   output logic        o_con_Stall,
   output logic        o_con_Valid,
   output logic [5:0]  o_data_Opcode,
   output logic [5:0]  o_data_Funct,
   output logic [4:0]  o_addr_Rs,
   output logic [4:0]  o_addr_Rt,
   output logic [4:0]  o_addr_Rd,
   output logic [31:0] o_data_ReadData1,
   output logic [31:0] o_data_ReadData2,
   output logic [31:0] o_data_SignImm,
   output logic [31:0] o_addr_NextPC,
   output logic [31:0] o_addr_BranchTarget
);

   logic [31:0] r_instr;
   logic [31:0] r_nextpc;
   logic        r_valid;
   logic [31:0] r_regs [32];

   logic [4:0]  w_rs, w_rt;
   logic [31:0] w_simm;
   logic        w_wr_en;

   assign w_rs    = r_instr[25:21];
   assign w_rt    = r_instr[20:16];
   assign w_simm  = {{16{r_instr[15]}}, r_instr[15:0]};
   assign w_wr_en = i_con_RegWrite && (i_addr_WriteReg != 5'd0);

   // Not qualified by r_valid: a spurious stall on a bubble costs nothing.
   assign o_con_Stall = i_con_ExMemRead && (i_addr_ExRt != 5'd0) &&
                        ((i_addr_ExRt == w_rs) || (i_addr_ExRt == w_rt));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instr  <= NOP_INSTR;
         r_nextpc <= '0;
         r_valid  <= 1'b0;
      end else if (i_con_Flush) begin
         r_instr  <= NOP_INSTR;
         r_nextpc <= '0;
         r_valid  <= 1'b0;
      end else if (!(i_con_Stall || o_con_Stall)) begin
         r_instr  <= i_data_Instr;
         r_nextpc <= i_addr_NextPC;
         r_valid  <= 1'b1;
      end
   end

   // Write-back is independent of stall/flush; entry 0 is never written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[i_addr_WriteReg] <= i_data_WriteData;
      end
   end

`ifdef DECODE_REGFILE_BYPASS_EN
   assign o_data_ReadData1 = (w_wr_en && (i_addr_WriteReg == w_rs)) ? i_data_WriteData : r_regs[w_rs];
   assign o_data_ReadData2 = (w_wr_en && (i_addr_WriteReg == w_rt)) ? i_data_WriteData : r_regs[w_rt];
`else
   assign o_data_ReadData1 = r_regs[w_rs];
   assign o_data_ReadData2 = r_regs[w_rt];
`endif

   assign o_con_Valid         = r_valid && !o_con_Stall;
   assign o_data_Opcode       = r_instr[31:26];
   assign o_data_Funct        = r_instr[5:0];
   assign o_addr_Rs           = w_rs;
   assign o_addr_Rt           = w_rt;
   assign o_addr_Rd           = r_instr[15:11];
   assign o_data_SignImm      = w_simm;
   assign o_addr_NextPC       = r_nextpc;
   assign o_addr_BranchTarget = r_nextpc + {w_simm[29:0], 2'b00};

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode; expected values are hand-computed constants.
module tb_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr, nextpc_in;
   logic        stall_in, flush, regwrite, exmemread;
   logic [4:0]  wreg, exrt;
   logic [31:0] wdata;
   logic        stall_out, valid;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rd1, rd2, simm, nextpc_out, btarget;

   int n_cmp = 0;
   int n_err = 0;

   decode dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_data_Instr(instr), .i_addr_NextPC(nextpc_in),
      .i_con_Stall(stall_in), .i_con_Flush(flush),
      .i_con_RegWrite(regwrite), .i_addr_WriteReg(wreg), .i_data_WriteData(wdata),
      .i_con_ExMemRead(exmemread), .i_addr_ExRt(exrt),
      .o_con_Stall(stall_out), .o_con_Valid(valid),
      .o_data_Opcode(opcode), .o_data_Funct(funct),
      .o_addr_Rs(rs), .o_addr_Rt(rt), .o_addr_Rd(rd),
      .o_data_ReadData1(rd1), .o_data_ReadData2(rd2),
      .o_data_SignImm(simm), .o_addr_NextPC(nextpc_out),
      .o_addr_BranchTarget(btarget)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; instr = '0; nextpc_in = '0; stall_in = 1'b0; flush = 1'b0;
      regwrite = 1'b0; wreg = '0; wdata = '0; exmemread = 1'b0; exrt = '0;
      #3;
      chk("rst_valid", valid, 0);
      chk("rst_nextpc", nextpc_out, 0);
      chk("rst_btarget", btarget, 0);
      chk("rst_rd1", rd1, 0);
      chk("rst_simm", simm, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_stall", stall_out, 0);

      @(negedge clk);
      rst_n = 1'b1;
      // write r8 while a NOP enters IF/ID
      regwrite = 1'b1; wreg = 5'd8; wdata = 32'h1234_5678;
      step();
      regwrite = 1'b0;
      instr = 32'h8D09_FFFC; nextpc_in = 32'h0000_0104;
      step();
      chk("lw_rs", rs, 8);
      chk("lw_rt", rt, 9);
      chk("lw_opcode", opcode, 6'h23);
      chk("lw_rd1", rd1, 32'h1234_5678);
      chk("lw_rd2", rd2, 0);
      chk("lw_simm", simm, 32'hFFFF_FFFC);
      chk("lw_btarget", btarget, 32'h0000_00F4);
      chk("lw_nextpc", nextpc_out, 32'h0000_0104);
      chk("lw_valid", valid, 1);

      // add $10,$9,$9 behind a load to $9
      instr = 32'h0129_5020; nextpc_in = 32'h0000_0108;
      step();
      chk("add_valid", valid, 1);
      exmemread = 1'b1; exrt = 5'd9;
      instr = 32'h1111_1111; nextpc_in = 32'h0000_010C;
      #1;
      chk("lu_stall", stall_out, 1);
      chk("lu_valid", valid, 0);
      step();
      exmemread = 1'b0;
      #1;
      chk("lu_hold_rd", rd, 10);
      chk("lu_hold_funct", funct, 6'h20);
      chk("lu_hold_nextpc", nextpc_out, 32'h0000_0108);
      chk("lu_release_stall", stall_out, 0);
      chk("lu_release_valid", valid, 1);
      exmemread = 1'b1; exrt = 5'd0;
      #1;
      chk("lu_rt0_nostall", stall_out, 0);
      exmemread = 1'b0;

      // external stall holds, then flush wins over stall
      stall_in = 1'b1;
      step();
      chk("xstall_hold_nextpc", nextpc_out, 32'h0000_0108);
      flush = 1'b1;
      step();
      chk("flush_valid", valid, 0);
      chk("flush_opcode", opcode, 0);
      chk("flush_funct", funct, 0);
      chk("flush_nextpc", nextpc_out, 0);
      stall_in = 1'b0; flush = 1'b0;

      // addi $0,$5,1 : rs=5, rt=0
      instr = 32'h20A0_0001; nextpc_in = 32'h0000_0200;
      regwrite = 1'b1; wreg = 5'd0; wdata = 32'hDEAD_BEEF;
      step();
      #1;
      chk("r0_same_cycle", rd2, 0);
      step();
      regwrite = 1'b0;
      #1;
      chk("r0_after", rd2, 0);
      chk("r5_before", rd1, 0);
      regwrite = 1'b1; wreg = 5'd5; wdata = 32'hCAFE_0001;
      #1;
`ifdef DECODE_REGFILE_BYPASS_EN
      chk("r5_same_cycle", rd1, 32'hCAFE_0001);
`else
      chk("r5_same_cycle", rd1, 0);
`endif
      step();
      regwrite = 1'b0;
      #1;
      chk("r5_next_cycle", rd1, 32'hCAFE_0001);

      // beq $0,$0,1 at the top of the address space
      instr = 32'h1000_0001; nextpc_in = 32'hFFFF_FFFC;
      step();
      chk("wrap_simm", simm, 1);
      chk("wrap_btarget", btarget, 0);

      // reset asserted mid-cycle while stalled with a valid instruction
      instr = 32'h8D09_FFFC; nextpc_in = 32'h0000_0104;
      step();
      chk("pre_rst_valid", valid, 1);
      chk("pre_rst_rd1", rd1, 32'h1234_5678);
      stall_in = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", valid, 0);
      chk("midrst_nextpc", nextpc_out, 0);
      chk("midrst_rd1", rd1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
